sram_ctrl: RTL and testbench



---
 rtl/sram_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: valid/ready requests, per-bit write mask,
// 2-entry read response buffer with credit-based back-pressure, optional zero-fill.
module sram_ctrl #(
   parameter int AW            = 11,
   parameter int DW            = 39,
   parameter int DEPTH         = 2**AW,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          REQ_VALID,
   output logic          REQ_READY,
   input  logic          REQ_WE,
   input  logic [AW-1:0] REQ_ADR,
   input  logic [DW-1:0] REQ_D,
   input  logic [DW-1:0] REQ_MASK,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic [DW-1:0] RSP_Q,
   output logic          INIT_DONE
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   localparam state_t RST_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          inflight_q, inflight_d;
   logic [1:0]    buf_cnt_q, buf_cnt_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   logic          accept, push, pop;
   logic          mem_we, mem_re;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata, mem_wmask;

   assign push      = inflight_q;
   assign pop       = RSP_VALID && RSP_READY;
   assign accept    = REQ_VALID && REQ_READY;
   assign RSP_VALID = (buf_cnt_q != 2'd0);
   assign RSP_Q     = head_q;
   // RST_N gating keeps both outputs low during reset even when the FSM resets into RUN.
   assign INIT_DONE = RST_N && (state_q == ST_RUN);
   assign REQ_READY = INIT_DONE && (((buf_cnt_q + {1'b0, inflight_q}) < 2'd2) || pop);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      inflight_d = accept && !REQ_WE;
      mem_we     = accept && REQ_WE;
      mem_re     = accept && !REQ_WE;
      mem_adr    = REQ_ADR;
      mem_wdata  = REQ_D;
      mem_wmask  = REQ_MASK;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_re    = 1'b0;
         mem_adr   = cnt_q;
         mem_wdata = '0;
         mem_wmask = '1;
         cnt_d     = cnt_q + 1'b1;
         if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end
   end

   // Two-register FIFO: head feeds RSP_Q and is left untouched when the buffer
   // drains, so the last delivered value stays visible.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      buf_cnt_d = buf_cnt_q;
      case (buf_cnt_q)
         2'd0: if (push) begin
            head_d    = rdata_q;
            buf_cnt_d = 2'd1;
         end
         2'd1: begin
            if (push && pop) head_d = rdata_q;
            else if (push) begin
               tail_d    = rdata_q;
               buf_cnt_d = 2'd2;
            end else if (pop) buf_cnt_d = 2'd0;
         end
         default: if (pop) begin
            head_d = tail_q;
            if (push) tail_d = rdata_q;
            else buf_cnt_d = 2'd1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= RST_STATE;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         buf_cnt_q  <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         buf_cnt_q  <= buf_cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Array model: synchronous read, per-bit write enable; contents survive reset.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         for (int i = 0; i < DW; i++)
            if (mem_wmask[i]) mem[mem_adr][i] <= mem_wdata[i];
      end
      if (mem_re) rdata_q <= mem[mem_adr];
   end

   a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
      !(push && !pop && buf_cnt_q == 2'd2));

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (AW=4, zero-fill on): init sweep, masked writes,
// streaming reads, back-pressure, read-after-write and asynchronous reset.
module tb_sram_ctrl;
   localparam int AW = 4;
   localparam int DW = 39;
   localparam logic [DW-1:0] ONES = '1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          REQ_VALID = 1'b0, REQ_WE = 1'b0;
   logic          REQ_READY;
   logic [AW-1:0] REQ_ADR = '0;
   logic [DW-1:0] REQ_D = '0, REQ_MASK = '0;
   logic          RSP_VALID, RSP_READY = 1'b0, INIT_DONE;
   logic [DW-1:0] RSP_Q;

   int n_cmp = 0, n_err = 0, cyc = 0;
   logic [DW-1:0] rsp_d[$];
   int            rsp_c[$];

   sram_ctrl #(.AW(AW), .DW(DW), .DEPTH(16), .INIT_ON_RESET(1'b1)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_ADR(REQ_ADR), .REQ_D(REQ_D), .REQ_MASK(REQ_MASK),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Q(RSP_Q),
      .INIT_DONE(INIT_DONE)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Record every response handshake with the cycle it occurs in.
   always @(negedge CLK)
      if (RST_N && RSP_VALID && RSP_READY) begin
         rsp_d.push_back(RSP_Q);
         rsp_c.push_back(cyc);
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request and hold it until accepted; t = cycle of the accepting edge.
   task automatic issue(input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] d, input logic [DW-1:0] m, output int t);
      bit got = 0;
      REQ_VALID = 1'b1; REQ_WE = we; REQ_ADR = adr; REQ_D = d; REQ_MASK = m;
      t = -1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if (REQ_READY) begin
            got = 1;
            t = cyc;
         end
         @(posedge CLK); #1;
      end
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      REQ_VALID = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      int t0, t1, bad;
      int ts[16];

      // Reset state
      #3;
      chk("rst_req_ready", REQ_READY, 0);
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_q", RSP_Q, 0);
      chk("rst_init_done", INIT_DONE, 0);

      // Init sweep: 16 cycles of REQ_READY=0, then RUN
      @(posedge CLK); #1;
      RST_N = 1'b1;
      RSP_READY = 1'b1;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         if (REQ_READY !== 1'b0 || INIT_DONE !== 1'b0) bad++;
         @(posedge CLK);
      end
      #1;
      chk("init_busy_cycles", bad, 0);
      chk("init_done", INIT_DONE, 1);
      chk("ready_after_init", REQ_READY, 1);

      // Read whole array back-to-back: all zero, latency 2
      rsp_d.delete(); rsp_c.delete();
      for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, '0, ts[a]);
      idle(6);
      chk("init_rd_stream", ts[15] - ts[0], 15);
      chk("init_rd_count", rsp_d.size(), 16);
      bad = 0;
      foreach (rsp_d[i]) if (rsp_d[i] !== '0) bad++;
      chk("init_rd_zero", bad, 0);
      if (rsp_c.size() == 16) begin
         chk("init_rd_first_lat", rsp_c[0], ts[0] + 2);
         chk("init_rd_last_lat", rsp_c[15], ts[0] + 17);
      end else chk("init_rd_lat_count", rsp_c.size(), 16);

      // Read-after-write on consecutive cycles
      rsp_d.delete(); rsp_c.delete();
      issue(1'b1, 4'd9, 39'h1234, ONES, t0);
      issue(1'b0, 4'd9, '0, '0, t1);
      idle(5);
      chk("raw_b2b", t1, t0 + 1);
      chk("raw_count", rsp_d.size(), 1);
      if (rsp_d.size() == 1) begin
         chk("raw_data", rsp_d[0], 39'h1234);
         chk("raw_cycle", rsp_c[0], t0 + 3);
      end

      // Masked write: clear only the low byte
      rsp_d.delete(); rsp_c.delete();
      issue(1'b1, 4'd5, 39'h7F_FFFF_FFFF, ONES, t0);
      issue(1'b1, 4'd5, 39'h00_0000_0000, 39'h00_0000_00FF, t0);
      issue(1'b0, 4'd5, '0, '0, t0);
      idle(5);
      chk("mask_count", rsp_d.size(), 1);
      if (rsp_d.size() == 1) chk("mask_data", rsp_d[0], 39'h7F_FFFF_FF00);

      // 8 writes then 8 back-to-back reads, responses in order on consecutive cycles
      rsp_d.delete(); rsp_c.delete();
      for (int a = 0; a < 8; a++) issue(1'b1, AW'(a), 39'h3C_DEAD_0000 + 39'(a), ONES, ts[a]);
      chk("wr_stream", ts[7] - ts[0], 7);
      for (int a = 0; a < 8; a++) issue(1'b0, AW'(a), '0, '0, ts[a]);
      idle(6);
      chk("rd8_stream", ts[7] - ts[0], 7);
      chk("rd8_count", rsp_d.size(), 8);
      bad = 0;
      foreach (rsp_d[i]) begin
         if (rsp_d[i] !== 39'h3C_DEAD_0000 + 39'(i)) bad++;
         if (rsp_c[i] !== ts[0] + 2 + i) bad++;
      end
      chk("rd8_order_timing", bad, 0);

      // Back-pressure: exactly two reads accepted while RSP_READY=0
      rsp_d.delete(); rsp_c.delete();
      RSP_READY = 1'b0;
      REQ_VALID = 1'b1; REQ_WE = 1'b0;
      t0 = 0;
      for (int k = 0; k < 6; k++) begin
         REQ_ADR = AW'(t0);
         @(negedge CLK);
         if (REQ_READY) t0++;
         @(posedge CLK); #1;
      end
      REQ_VALID = 1'b0;
      @(negedge CLK);
      chk("bp_accepted", t0, 2);
      chk("bp_ready_low", REQ_READY, 0);
      chk("bp_rsp_valid", RSP_VALID, 1);
      chk("bp_head_hold", RSP_Q, 39'h3C_DEAD_0000);
      chk("bp_no_rsp", rsp_d.size(), 0);
      @(posedge CLK); #1;
      RSP_READY = 1'b1;
      idle(4);
      chk("bp_drain_count", rsp_d.size(), 2);
      if (rsp_d.size() == 2) begin
         chk("bp_drain_0", rsp_d[0], 39'h3C_DEAD_0000);
         chk("bp_drain_1", rsp_d[1], 39'h3C_DEAD_0001);
      end
      chk("bp_rsp_q_hold_empty", RSP_Q, 39'h3C_DEAD_0001);

      // Reset with a full buffer
      RSP_READY = 1'b0;
      issue(1'b0, 4'd2, '0, '0, t0);
      issue(1'b0, 4'd3, '0, '0, t0);
      idle(2);
      @(negedge CLK);
      chk("mid_full_valid", RSP_VALID, 1);
      chk("mid_full_ready", REQ_READY, 0);
      #2 RST_N = 1'b0;
      #1;
      chk("mid_rst_valid", RSP_VALID, 0);
      chk("mid_rst_q", RSP_Q, 0);
      chk("mid_rst_ready", REQ_READY, 0);
      @(posedge CLK); #1;
      rsp_d.delete(); rsp_c.delete();
      RST_N = 1'b1;
      RSP_READY = 1'b1;
      idle(20);
      chk("mid_rst_init_done", INIT_DONE, 1);
      chk("mid_rst_no_stale", rsp_d.size(), 0);
      issue(1'b0, 4'd3, '0, '0, t0);
      idle(5);
      chk("mid_rst_refill_count", rsp_d.size(), 1);
      if (rsp_d.size() == 1) chk("mid_rst_refill_zero", rsp_d[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
